pll_rst_seq: RTL and testbench

PLL_RST_SEQ -- requirements
Module: pll_rst_seq

---
 rtl/pll_rst_seq_pkg.sv | 41 ++++
 rtl/pll_rst_seq_sync_2ff.sv | 32 +++
 rtl/pll_rst_seq.sv | 168 ++++++++++++++++
 tb/tb_pll_rst_seq.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pll_rst_seq_pkg
// Description : Shared types and constants for the PLL reset sequencer:
//               sequencer state encoding, default timing constants and the
//               helper that sizes the shared down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_rst_seq_pkg;

    // Sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        RST_HOLD  = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_t;

    // Default timing constants (in reference-clock cycles)
    localparam int unsigned c_pwr_up_cycles       = 8;
    localparam int unsigned c_lock_stable_cycles  = 16;
    localparam int unsigned c_lock_timeout_cycles = 64;
    localparam int unsigned c_max_retries         = 3;

    // Width of a down-counter able to hold the largest of the three loads
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        int unsigned w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = $clog2(m + 1);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_rst_seq_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Single-bit two-flop synchronizer with asynchronous active-low
//               reset to 0. A change on i_d appears on o_q two clk edges later.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic resetn,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : pll_rst_seq
// Description : PLL power-up / lock sequencer. Holds the PLL in reset, waits
//               for a stable synchronized LOCK with timeout and retries, then
//               releases the active-low reset of the PLL-clocked logic.
// Config      : PLL_RST_SEQ_RELOCK_EN - when defined, loss of lock in RUN
//               restarts the sequence (retry count cleared); when undefined,
//               loss of lock in RUN is terminal (FAIL).
// Revision    : 1.0 - initial release
// ============================================================================
module pll_rst_seq
    import pll_rst_seq_pkg::*;
#(
    parameter int unsigned PWR_UP_CYCLES       = c_pwr_up_cycles,       // >= 1
    parameter int unsigned LOCK_STABLE_CYCLES  = c_lock_stable_cycles,  // >= 2
    parameter int unsigned LOCK_TIMEOUT_CYCLES = c_lock_timeout_cycles, // >= 1
    parameter int unsigned MAX_RETRIES         = c_max_retries          // 1..15
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       lock_i,
    output logic       pll_reset_o,
    output logic       rstn_o,
    output logic       locked_o,
    output logic       fail_o,
    output logic [3:0] retry_cnt_o
);

    localparam int unsigned c_cnt_w = cnt_width(PWR_UP_CYCLES, LOCK_STABLE_CYCLES,
                                                LOCK_TIMEOUT_CYCLES);

    // The counter expires at zero, so a load of N-1 gives N cycles in a state.
    // STABLE loads N-2 because the WAIT_LOCK cycle that first sees lock_s
    // already counts as the first of the consecutive locked cycles.
    localparam logic [c_cnt_w-1:0] c_hold_load   = c_cnt_w'(PWR_UP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_wait_load   = c_cnt_w'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_stable_load = c_cnt_w'(LOCK_STABLE_CYCLES - 2);
    localparam logic [3:0]         c_retry_limit = 4'(MAX_RETRIES);

    pll_state_t         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [3:0]         r_retry;
    logic               r_pll_reset;
    logic               r_rstn;
    logic               r_locked;
    logic               r_fail;

    logic               w_lock_s;
    pll_state_t         w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [c_cnt_w-1:0] w_cnt_dec;
    logic [3:0]         w_retry_nxt;
    logic [3:0]         w_retry_inc;
    logic               w_pll_reset_nxt;
    logic               w_rstn_nxt;
    logic               w_locked_nxt;
    logic               w_fail_nxt;

    sync_2ff u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .i_d    (lock_i),
        .o_q    (w_lock_s)
    );

    assign w_cnt_dec   = r_cnt - 1'b1;
    assign w_retry_inc = (r_retry == 4'd15) ? 4'd15 : r_retry + 4'd1;

    // Next-state, counter, retry and output decode of the next state
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry;

        unique case (r_state)
            RST_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = c_wait_load;
                end else begin
                    w_cnt_nxt   = w_cnt_dec;
                end
            end
            WAIT_LOCK: begin
                // Lock takes priority over a timeout expiring in the same cycle
                if (w_lock_s) begin
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = c_stable_load;
                end else if (r_cnt == '0) begin
                    w_retry_nxt = w_retry_inc;
                    if (w_retry_inc == c_retry_limit) begin
                        w_state_nxt = FAIL;
                    end else begin
                        w_state_nxt = RST_HOLD;
                        w_cnt_nxt   = c_hold_load;
                    end
                end else begin
                    w_cnt_nxt   = w_cnt_dec;
                end
            end
            STABLE: begin
                // A dropout is not a failed attempt: re-arm the timeout only
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = c_wait_load;
                end else if (r_cnt == '0) begin
                    w_state_nxt = RUN;
                    w_retry_nxt = 4'd0;
                end else begin
                    w_cnt_nxt   = w_cnt_dec;
                end
            end
            RUN: begin
                if (!w_lock_s) begin
`ifdef PLL_RST_SEQ_RELOCK_EN
                    w_state_nxt = RST_HOLD;
                    w_cnt_nxt   = c_hold_load;
                    w_retry_nxt = 4'd0;
`else
                    w_state_nxt = FAIL;
`endif
                end
            end
            FAIL: begin
                // Terminal until resetn
            end
            default: begin
                w_state_nxt = RST_HOLD;
                w_cnt_nxt   = c_hold_load;
            end
        endcase

        w_pll_reset_nxt = (w_state_nxt == RST_HOLD) || (w_state_nxt == FAIL);
        w_rstn_nxt      = (w_state_nxt == RUN);
        w_locked_nxt    = (w_state_nxt == RUN);
        w_fail_nxt      = (w_state_nxt == FAIL);
    end

    // State, counter and registered outputs; outputs always match r_state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= RST_HOLD;
            r_cnt       <= c_hold_load;
            r_retry     <= 4'd0;
            r_pll_reset <= 1'b1;
            r_rstn      <= 1'b0;
            r_locked    <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_pll_reset <= w_pll_reset_nxt;
            r_rstn      <= w_rstn_nxt;
            r_locked    <= w_locked_nxt;
            r_fail      <= w_fail_nxt;
        end
    end

    assign pll_reset_o = r_pll_reset;
    assign rstn_o      = r_rstn;
    assign locked_o    = r_locked;
    assign fail_o      = r_fail;
    assign retry_cnt_o = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_pll_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_rst_seq
// Description : Self-checking bench for pll_rst_seq (default parameters).
//               A timestamp/run-length reference model predicts outputs for
//               randomized lock_i waveforms; scenario tasks add fixed-point
//               checks at the sequence landmarks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_rst_seq;

    localparam int PWR  = 8;
    localparam int STAB = 16;
    localparam int TMO  = 64;
    localparam int MAXR = 3;

    localparam int M_HOLD = 0;
    localparam int M_WAIT = 1;
    localparam int M_RUN  = 2;
    localparam int M_DEAD = 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       lock_i = 1'b0;
    logic       pll_reset_o;
    logic       rstn_o;
    logic       locked_o;
    logic       fail_o;
    logic [3:0] retry_cnt_o;
    logic [7:0] obs;

    int checks = 0;
    int failures = 0;

    // Reference model: mode, edge count since release, timestamp of last
    // phase start, run length of consecutive locked samples, retry count
    int   m_mode, m_k, m_mark, m_run, m_retry;
    logic lh0, lh1, lh2;

    pll_rst_seq dut (
        .clk         (clk),
        .resetn      (resetn),
        .lock_i      (lock_i),
        .pll_reset_o (pll_reset_o),
        .rstn_o      (rstn_o),
        .locked_o    (locked_o),
        .fail_o      (fail_o),
        .retry_cnt_o (retry_cnt_o)
    );

    always #5 clk = ~clk;

    assign obs = {pll_reset_o, rstn_o, locked_o, fail_o, retry_cnt_o};

    function automatic void model_release();
        m_mode = M_HOLD; m_k = 0; m_mark = 0; m_run = 0; m_retry = 0;
        lh0 = 1'b0; lh1 = 1'b0; lh2 = 1'b0;
    endfunction

    // v is the lock level the sequencer sees at this edge (two-flop delayed)
    function automatic void model_edge(input logic v);
        m_k++;
        case (m_mode)
            M_HOLD: if (m_k - m_mark == PWR) begin
                m_mode = M_WAIT; m_mark = m_k; m_run = 0;
            end
            M_WAIT: if (v) begin
                m_run++;
                if (m_run == STAB) begin m_mode = M_RUN; m_retry = 0; end
            end else if (m_run > 0) begin
                m_run = 0; m_mark = m_k;
            end else if (m_k - m_mark == TMO) begin
                m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                if (m_retry == MAXR) m_mode = M_DEAD;
                else begin m_mode = M_HOLD; m_mark = m_k; end
            end
            M_RUN: if (!v) begin
`ifdef PLL_RST_SEQ_RELOCK_EN
                m_mode = M_HOLD; m_mark = m_k; m_retry = 0;
`else
                m_mode = M_DEAD;
`endif
            end
            default: ;
        endcase
    endfunction

    function automatic logic [7:0] m_exp();
        m_exp = {(m_mode == M_HOLD) || (m_mode == M_DEAD), m_mode == M_RUN,
                 m_mode == M_RUN, m_mode == M_DEAD, 4'(m_retry)};
    endfunction

    // Drive lock_i for the coming cycle, take one edge, settle 1 time unit
    task automatic step(input logic v);
        lh2 = lh1; lh1 = lh0; lh0 = v;
        lock_i = v;
        @(posedge clk);
        model_edge(lh2);
        #1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        lock_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        model_release();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        lock_i = 1'($urandom_range(0, 1));
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== 8'b1000_0000) begin
            failures++; $display("FAIL reset_held got=%b want=%b", obs, 8'b1000_0000);
        end
        lock_i = 1'b0;
        resetn = 1'b1;
        model_release();
        checks++;
        if (obs !== m_exp()) begin
            failures++; $display("FAIL reset_release got=%b want=%b", obs, m_exp());
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b0);
            checks++;
            if (pll_reset_o !== (m_k < PWR)) begin
                failures++; $display("FAIL reset_pwrup k=%0d got=%b want=%b", m_k, pll_reset_o, m_k < PWR);
            end
        end
    endtask

    task automatic test_nominal();
        for (int it = 0; it < 3; it++) begin
            int lk;
            lk = (it == 0) ? 13 : int'($urandom_range(9, 60));
            apply_reset();
            for (int k = 0; k < lk + 24; k++) begin
                step(k >= lk);
                checks++;
                if (obs !== m_exp()) begin
                    failures++; $display("FAIL nominal k=%0d got=%b want=%b", m_k, obs, m_exp());
                end
                if (m_k == lk + 17 || m_k == lk + 18) begin
                    checks++;
                    if ({rstn_o, locked_o, retry_cnt_o} !== {{2{m_k == lk + 18}}, 4'd0}) begin
                        failures++; $display("FAIL nominal_release k=%0d got=%b%b/%0d want=%b/0",
                                             m_k, rstn_o, locked_o, retry_cnt_o, m_k == lk + 18);
                    end
                end
            end
        end
    endtask

    task automatic test_no_lock();
        apply_reset();
        for (int k = 0; k < 230; k++) begin
            step(1'b0);
            checks++;
            if (obs !== m_exp()) begin
                failures++; $display("FAIL nolock k=%0d got=%b want=%b", m_k, obs, m_exp());
            end
            if (m_k == 72 || m_k == 144) begin
                checks++;
                if ({pll_reset_o, retry_cnt_o} !== {1'b1, 4'(m_k / 72)}) begin
                    failures++; $display("FAIL nolock_retry k=%0d got=%b/%0d want=1/%0d",
                                         m_k, pll_reset_o, retry_cnt_o, m_k / 72);
                end
            end
            if (m_k >= 216) begin
                checks++;
                if ({fail_o, pll_reset_o, rstn_o, locked_o} !== 4'b1100) begin
                    failures++; $display("FAIL nolock_fail k=%0d got=%b want=1100",
                                         m_k, {fail_o, pll_reset_o, rstn_o, locked_o});
                end
            end
        end
    endtask

    task automatic test_glitch();
        for (int it = 0; it < 2; it++) begin
            int lk;
            lk = int'($urandom_range(9, 40));
            apply_reset();
            for (int k = 0; k < lk + 40; k++) begin
                step((k >= lk) && (k != lk + 10));
                checks++;
                if (obs !== m_exp()) begin
                    failures++; $display("FAIL glitch k=%0d got=%b want=%b", m_k, obs, m_exp());
                end
                if (m_k == lk + 28 || m_k == lk + 29) begin
                    checks++;
                    if ({rstn_o, retry_cnt_o} !== {m_k == lk + 29, 4'd0}) begin
                        failures++; $display("FAIL glitch_run k=%0d got=%b/%0d want=%b/0",
                                             m_k, rstn_o, retry_cnt_o, m_k == lk + 29);
                    end
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int a = 0; a < 2; a++) begin
            int lk;
            lk = 69 + 72 * a;
            apply_reset();
            for (int k = 0; k < lk + 20; k++) begin
                step(k >= lk);
                checks++;
                if (obs !== m_exp()) begin
                    failures++; $display("FAIL simult k=%0d got=%b want=%b", m_k, obs, m_exp());
                end
                if (m_k == lk + 3) begin
                    checks++;
                    if ({pll_reset_o, fail_o, retry_cnt_o} !== {2'b00, 4'(a)}) begin
                        failures++; $display("FAIL simult_edge k=%0d got=%b%b/%0d want=00/%0d",
                                             m_k, pll_reset_o, fail_o, retry_cnt_o, a);
                    end
                end
            end
        end
    endtask

    task automatic test_loss_of_lock();
        int lk, dd;
        lk = int'($urandom_range(9, 40));
        dd = lk + 18 + int'($urandom_range(1, 10));
        apply_reset();
        for (int k = 0; k < dd + 40; k++) begin
            step(((k >= lk) && (k < dd)) || (k >= dd + 15));
            checks++;
            if (obs !== m_exp()) begin
                failures++; $display("FAIL loss k=%0d got=%b want=%b", m_k, obs, m_exp());
            end
            if (m_k == dd + 2 || m_k == dd + 3) begin
                checks++;
                if (rstn_o !== (m_k == dd + 2)) begin
                    failures++; $display("FAIL loss_rstn k=%0d got=%b want=%b", m_k, rstn_o, m_k == dd + 2);
                end
            end
`ifdef PLL_RST_SEQ_RELOCK_EN
            if (m_k >= dd + 3 && m_k <= dd + 11) begin
                checks++;
                if ({pll_reset_o, fail_o} !== {m_k != dd + 11, 1'b0}) begin
                    failures++; $display("FAIL loss_relock k=%0d got=%b%b want=%b0",
                                         m_k, pll_reset_o, fail_o, m_k != dd + 11);
                end
            end
`else
            if (m_k >= dd + 3) begin
                checks++;
                if ({fail_o, pll_reset_o} !== 2'b11) begin
                    failures++; $display("FAIL loss_fail k=%0d got=%b%b want=11", m_k, fail_o, pll_reset_o);
                end
            end
`endif
        end
    endtask

    task automatic test_mid_reset();
        for (int sc = 0; sc < 3; sc++) begin
            int n, lk;
            n  = (sc == 0) ? 160 + int'($urandom_range(0, 20)) : (sc == 1) ? 45 : 230;
            lk = (sc == 1) ? 10 : 100000;
            apply_reset();
            for (int k = 0; k < n; k++) begin
                step(k >= lk);
                checks++;
                if (obs !== m_exp()) begin
                    failures++; $display("FAIL midrst_pre sc=%0d k=%0d got=%b want=%b", sc, m_k, obs, m_exp());
                end
            end
            if (sc == 0) begin
                checks++;
                if ({pll_reset_o, retry_cnt_o} !== 5'b0_0010) begin
                    failures++; $display("FAIL midrst_wait got=%b/%0d want=0/2", pll_reset_o, retry_cnt_o);
                end
            end
            resetn = 1'b0;
            #1;
            checks++;
            if (obs !== 8'b1000_0000) begin
                failures++; $display("FAIL midrst_async sc=%0d got=%b want=%b", sc, obs, 8'b1000_0000);
            end
            apply_reset();
            for (int k = 0; k < 12; k++) begin
                step(1'b0);
                checks++;
                if (obs !== m_exp() || retry_cnt_o !== 4'd0) begin
                    failures++; $display("FAIL midrst_restart sc=%0d k=%0d got=%b want=%b", sc, m_k, obs, m_exp());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_no_lock();
        test_glitch();
        test_simultaneous();
        test_loss_of_lock();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
